// File: rtl/fp_norm_seq.sv
// Leading-zero normalizer for single-precision add/sub results.
// Shifts the mantissa left one bit per cycle, decrementing the exponent,
// until the hidden-one position is set, or flushes to zero on underflow.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for an operand, in_ready high
// ST_SHIFT | one left shift (or an underflow flush) per cycle
// ST_DONE  | result presented, out_valid high until out_ready
module fp_norm_seq #(
  parameter int EW = 8,
  parameter int FW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_s,
  input  logic [EW-1:0] in_e,
  input  logic [FW:0]   in_m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [FW-1:0] out_m,
  output logic [4:0]    out_lz,
  output logic          out_uflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state;
  logic [FW:0]   m;
  logic [EW-1:0] e;
  logic          s;
  logic [4:0]    lz;
  logic          uflow;
  logic          e_low;

  // Checking e<=1 before each decrement keeps the exponent from wrapping.
  assign e_low = (e <= EW'(1));

  // Sequencer and working registers; the result registers drive the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      m     <= '0;
      e     <= '0;
      s     <= 1'b0;
      lz    <= '0;
      uflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            lz    <= '0;
            uflow <= 1'b0;
            if (in_m == '0) begin
              s     <= 1'b0;
              e     <= '0;
              m     <= '0;
              state <= ST_DONE;
            end else begin
              s     <= in_s;
              e     <= in_e;
              m     <= in_m;
              state <= in_m[FW] ? ST_DONE : ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (e_low) begin
            s     <= 1'b0;
            e     <= '0;
            m     <= '0;
            uflow <= 1'b1;
            state <= ST_DONE;
          end else begin
            m  <= {m[FW-1:0], 1'b0};
            e  <= e - EW'(1);
            lz <= lz + 5'd1;
            if (m[FW-1]) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake flags depend only on state (and rst for in_ready).
  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);

  assign out_s     = s;
  assign out_e     = e;
  assign out_m     = m[FW-1:0];
  assign out_lz    = lz;
  assign out_uflow = uflow;

endmodule

// File: doc/fp_norm_seq.md
# fp_norm_seq

Multi-cycle leading-zero normalizer for single-precision add/sub results. It sits directly downstream of the floating-point add/sub stage. It accepts a sign, an exponent and a 24-bit mantissa whose bit 23 is the hidden-one position. It shifts the mantissa left one bit per cycle, decrementing the exponent, until bit 23 is set, and then emits a packed-ready sign, exponent and 23-bit fraction over a valid/ready handshake.

## Interface
- EW, 8, exponent width
- FW, 23, stored fraction width (internal mantissa is FW+1 bits)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept; high only in IDLE and only when rst=0
- in_s  in  1  sign
- in_e  in  EW  biased exponent
- in_m  in  FW+1  mantissa; bit FW is the hidden-one position
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- out_s  out  1  result sign
- out_e  out  EW  result exponent
- out_m  out  FW  result fraction (normalized mantissa without hidden bit)
- out_lz  out  5  number of left shifts applied
- out_uflow  out  1  result flushed to zero by exponent underflow

## Operation
- States: IDLE, SHIFT, DONE. Working registers: m (FW+1 bits), e (EW bits), s, lz (5 bits).
- IDLE: in_ready=1. On in_valid&in_ready, capture s/e/m and clear lz and uflow.
  - in_m==0: load zero result (s=0, e=0, m=0), uflow=0, go to DONE.
  - in_m[FW]==1: go to DONE unchanged.
  - Otherwise: go to SHIFT.
- SHIFT, one action per cycle:
  - If e<=1, flush: s=0, e=0, m=0, uflow=1, go to DONE. lz keeps the shifts already done.
  - Else: m=m<<1, e=e-1, lz=lz+1. If the new m[FW]==1, go to DONE; otherwise stay in SHIFT.
- DONE: out_valid=1 and outputs are stable. On out_ready, go to IDLE. No new input is accepted in DONE, including the cycle in which out_ready is seen.
- out_m = m[FW-1:0]. out_e, out_s, out_lz and out_uflow are driven directly from the working registers.
- Arithmetic rules:
  - The exponent never wraps, because the e<=1 check precedes every decrement.
  - lz never exceeds FW, so 5 bits suffice.
- Input e=0 with nonzero in_m and in_m[FW]=0 is treated as an underflow: flush on the first SHIFT cycle.
- Input e=0 with in_m[FW]=1 passes through unchanged, with no flush.

## Timing
- Reset values: out_valid=0, out_s=0, out_e=0, out_m=0, out_lz=0, out_uflow=0, state=IDLE. in_ready=0 while rst=1 and 1 in the first cycle after rst deasserts.
- rst asserted in any state, including mid-SHIFT or DONE with out_valid high, discards the operation. All outputs return to reset values at the next edge.
- Let T be the accept edge and k the leading-zero count of in_m with no underflow. out_valid rises after edge T+1+k.
  - in_m[FW]=1 or in_m=0: out_valid after T+1.
- Underflow: out_valid rises after edge T+1+j, where j is the number of shifts done before e reached 1.
- Throughput: one result per (2+k) cycles minimum. The IDLE cycle after the DONE handshake is mandatory.
- in_ready is a function of state and rst only, not of in_valid. out_valid is a function of state only, not of out_ready.
- If out_ready is held low, DONE holds indefinitely and the outputs do not change.

## Test plan
- Reset mid-SHIFT: accept in_m=24'h000001, e=8'd100, assert rst 5 cycles later -> next edge out_valid=0, all outputs 0, in_ready=0. After rst drops, in_ready=1.
- Already normalized: s=1, e=8'h80, m=24'hC00000, out_ready=1 -> out_valid 1 cycle after accept; out_s=1, out_e=8'h80, out_m=23'h400000, out_lz=0, out_uflow=0.
- Max shift: s=0, e=8'd100, m=24'h000001 -> out_valid 24 cycles after accept; out_e=8'd77, out_m=0, out_lz=23, out_uflow=0.
- Underflow: e=8'd3, m=24'h100000 -> two shifts then flush; out_valid 3 cycles after accept; out_s=0, out_e=0, out_m=0, out_lz=2, out_uflow=1.
- Zero input: s=1, e=8'h55, m=0 -> out_valid after 1 cycle; out_s=0, out_e=0, out_m=0, out_lz=0, out_uflow=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with a new operand -> outputs stable, in_ready=0. Pulse out_ready -> IDLE next cycle, new operand accepted the cycle after.
